// File: rtl/dom_share_decoder_fault_check_if.sv
`default_nettype none
// ============================================================================
// Module      : dom_share_decoder_fault_check_if
// Description : Handshake and data bundle between the masked core (master)
//               and the share decoder / fault checker (slave).
//               Input side : in_valid, in_ready, in_share0, in_share1, in_dup1
//               Output side: out_valid, out_ready, out_data, out_fault
//               Status     : fault_sticky, clear_fault
// Revision    : 1.0 - initial release
// ============================================================================
interface dom_share_decoder_fault_check_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_share0;
    logic [WIDTH-1:0] in_share1;
    logic [WIDTH-1:0] in_dup1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_fault;
    logic             fault_sticky;
    logic             clear_fault;

    // Driver side: the masked core feeding words and consuming results.
    modport master (
        output in_valid, in_share0, in_share1, in_dup1, out_ready, clear_fault,
        input  in_ready, out_valid, out_data, out_fault, fault_sticky
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_share0, in_share1, in_dup1, out_ready, clear_fault,
        output in_ready, out_valid, out_data, out_fault, fault_sticky
    );
endinterface
`default_nettype wire

// File: rtl/dom_share_decoder_fault_check.sv
`default_nettype none
// ============================================================================
// Module      : dom_share_decoder_fault_check
// Description : Receiving end of a first-order DOM masked datapath. Captures
//               share0, share1 and a redundant copy of share1 into separate
//               registers, then unmasks (share0 ^ share1) and compares share1
//               against its duplicate. A mismatching word is suppressed and
//               replaced by FAULT_VAL, with out_fault raised.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-high reset
//               bus (slave)  - in_valid/in_ready/in_share0/in_share1/in_dup1,
//                              out_valid/out_ready/out_data/out_fault,
//                              fault_sticky/clear_fault
// Parameters  : WIDTH     - share and result width (must match bus WIDTH)
//               FAULT_VAL - value driven on out_data for a faulty word
// Options     : SHARE_DEC_LOCKOUT_EN - when defined, a recorded fault locks
//               the input side until reset and clear_fault is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dom_share_decoder_fault_check #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] FAULT_VAL = '0
) (
    input  wire                             clk,
    input  wire                             rst,
    dom_share_decoder_fault_check_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_fault;
    logic             r_fault_sticky;
    logic [WIDTH-1:0] r_s0;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_d1;

    logic [WIDTH-1:0] w_res;
    logic             w_flt;
    logic             w_lock;
    logic             w_clear;

    // Shares are only combined after they sit in separate registers, so no
    // glitch on the input wires can ever expose an unmasked value.
    assign w_res = r_s0 ^ r_s1;
    assign w_flt = (r_s1 != r_d1);

`ifdef SHARE_DEC_LOCKOUT_EN
    // Once a fault is recorded the block refuses new words until reset.
    // clear_fault can only act while unlocked, i.e. when there is nothing to clear.
    assign w_lock  = r_fault_sticky;
    assign w_clear = bus.clear_fault & ~r_fault_sticky;
`else
    assign w_lock  = 1'b0;
    assign w_clear = bus.clear_fault;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_fault    <= 1'b0;
            r_fault_sticky <= 1'b0;
            r_s0           <= '0;
            r_s1           <= '0;
            r_d1           <= '0;
        end else begin
            // A fault registering in HOLD below overrides this clear.
            if (w_clear) begin
                r_fault_sticky <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_in_ready <= ~w_lock;
                    if (bus.in_valid && r_in_ready) begin
                        r_s0       <= bus.in_share0;
                        r_s1       <= bus.in_share1;
                        r_d1       <= bus.in_dup1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // A faulty word never reveals its unmasked value.
                    r_out_data  <= w_flt ? FAULT_VAL : w_res;
                    r_out_fault <= w_flt;
                    r_out_valid <= 1'b1;
                    if (w_flt) begin
                        r_fault_sticky <= 1'b1;
                    end
                    r_state <= S_OUT;
                end

                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        // Scrub masked material once the word has left.
                        r_s0        <= '0;
                        r_s1        <= '0;
                        r_d1        <= '0;
                        r_in_ready  <= ~w_lock;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_fault    = r_out_fault;
    assign bus.fault_sticky = r_fault_sticky;

endmodule
`default_nettype wire
